// File: rtl/aes_128_inv.sv
// aes_128_inv: iterative AES-128 decryption core, one inverse round per clock.
// Round keys are expanded once after reset and kept in registers.
module aes_128_inv #(
    parameter logic [127:0] KEY = 128'h11111111111111111111111111111111
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [63:0]  state_in,
    input  logic [1:0]   aes_in,
    output logic [127:0] out,
    output logic         out_valid,
    output logic         busy,
    output logic         key_ready
);
    localparam logic [1:0] KEY_PREP = 2'd0, IDLE = 2'd1, ROUND = 2'd2;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), shared by both S-boxes.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, y;
        r = 8'h01;
        y = a;
        for (int k = 1; k < 8; k++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{k[3]}} & x8) ^ ({8{k[2]}} & x4) ^ ({8{k[1]}} & x2) ^ ({8{k[0]}} & a);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gm(s[127-8*(4*c+r) -: 8], 4'he)
                                      ^ gm(s[127-8*(4*c+(r+1)%4) -: 8], 4'hb)
                                      ^ gm(s[127-8*(4*c+(r+2)%4) -: 8], 4'hd)
                                      ^ gm(s[127-8*(4*c+(r+3)%4) -: 8], 4'h9);
        return o;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [1:0]   fsm;
    logic [3:0]   cnt;
    logic [7:0]   rc;
    logic [127:0] s, isb, nxt;
    logic [63:0]  low_buf;
    logic [127:0] rks [0:10];

    always_comb begin
        isb = inv_shift_sub(s);
        nxt = inv_mix(isb ^ rks[cnt]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm       <= KEY_PREP;
            cnt       <= 4'd1;
            rc        <= 8'h01;
            s         <= '0;
            low_buf   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
            for (int i = 0; i < 11; i++) rks[i] <= (i == 0) ? KEY : '0;
        end else begin
            out_valid <= 1'b0;
            case (fsm)
                KEY_PREP: begin
                    rks[cnt] <= expand(rks[cnt - 4'd1], rc);
                    rc       <= xt(rc);
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd10) begin
                        key_ready <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                IDLE: begin
                    if (aes_in == 2'b00) low_buf <= state_in;
                    if (aes_in == 2'b01) begin
                        s    <= {state_in, low_buf} ^ rks[10];
                        cnt  <= 4'd9;
                        busy <= 1'b1;
                        fsm  <= ROUND;
                    end
                end
                default: begin
                    if (cnt == 4'd0) begin
                        out       <= isb ^ rks[0];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end else begin
                        s   <= nxt;
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_128_inv.sv
// tb_aes_128_inv: directed FIPS-197 / SP800-38A vectors through two cores with different keys,
// plus key-prep, back-to-back, buffer-reuse and mid-block reset sequences.
module tb_aes_128_inv;
    logic         clk, reset_n;
    logic [63:0]  state_in;
    logic [1:0]   aes_in;
    logic [127:0] out_a, out_b;
    logic         ov_a, ov_b, busy_a, busy_b, kr_a, kr_b;
    int           errors = 0, checks = 0;

    aes_128_inv #(.KEY(128'h2b7e151628aed2a6abf7158809cf4f3c)) dut_a (
        .clk(clk), .reset_n(reset_n), .state_in(state_in), .aes_in(aes_in),
        .out(out_a), .out_valid(ov_a), .busy(busy_a), .key_ready(kr_a));

    aes_128_inv #(.KEY(128'h000102030405060708090a0b0c0d0e0f)) dut_b (
        .clk(clk), .reset_n(reset_n), .state_in(state_in), .aes_in(aes_in),
        .out(out_b), .out_valid(ov_b), .busy(busy_b), .key_ready(kr_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sel;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t v [6];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic start(input logic [127:0] ct, input logic fresh);
        if (fresh) begin
            state_in = ct[63:0];
            aes_in   = 2'b00;
            @(negedge clk);
        end
        state_in = ct[127:64];
        aes_in   = 2'b01;
        @(negedge clk);
        aes_in   = 2'b10;
        state_in = '0;
    endtask

    // Called one negedge after the start edge; returns in the out_valid cycle.
    task automatic finish_block(input logic sel, input logic [127:0] pt, input string name,
                                input logic noise, input logic [127:0] prev, input logic chk_prev);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) check({name, " busy"}, sel ? busy_b : busy_a, 1);
            if (noise && k == 2) begin aes_in = 2'b00; state_in = 64'hdeadbeefcafef00d; end
            if (noise && k == 3) begin aes_in = 2'b01; state_in = 64'h0123456789abcdef; end
            if (noise && k == 4) begin aes_in = 2'b10; state_in = '0; end
            if (k == 9) begin
                check({name, " early valid"}, sel ? ov_b : ov_a, 0);
                if (chk_prev) check({name, " hold"}, sel ? out_b : out_a, prev);
            end
        end
        check({name, " valid"}, sel ? ov_b : ov_a, 1);
        check({name, " out"}, sel ? out_b : out_a, pt);
        check({name, " idle"}, sel ? busy_b : busy_a, 0);
    endtask

    initial begin
        int ov_seen;
        v[0] = '{1'b0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        v[1] = '{1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        v[2] = '{1'b0, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
        v[3] = '{1'b0, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        v[4] = '{1'b0, 128'h43b1cd7f598ece23881b00e3ed030688, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
        v[5] = '{1'b0, 128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710};
        reset_n  = 1'b0;
        aes_in   = 2'b10;
        state_in = '0;
        repeat (3) @(negedge clk);
        check("rst out", out_a, 0);
        check("rst valid", ov_a, 0);
        check("rst busy", busy_a, 0);
        check("rst key_ready", kr_a, 0);
        // Start requests during key expansion must be ignored.
        reset_n  = 1'b1;
        aes_in   = 2'b01;
        state_in = 64'h0000000000000123;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("kprep busy %0d", k), busy_a, 0);
            check($sformatf("kprep valid %0d", k), ov_a, 0);
            if (k == 9) check("key_ready early", kr_a, 0);
        end
        check("key_ready a", kr_a, 1);
        check("key_ready b", kr_b, 1);
        aes_in = 2'b10;
        @(negedge clk);
        check("kprep no start", busy_a, 0);
        for (int i = 0; i < 6; i++) begin
            start(v[i].ct, 1'b1);
            finish_block(v[i].sel, v[i].pt, $sformatf("vec%0d", i), 1'b0, '0, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d pulse", i), v[i].sel ? ov_b : ov_a, 0);
        end
        // Low buffer still holds v[5]; restart without a fresh low half, then back-to-back.
        start(v[5].ct, 1'b0);
        finish_block(1'b0, v[5].pt, "reuse", 1'b1, '0, 1'b0);
        start(v[5].ct, 1'b0);
        finish_block(1'b0, v[5].pt, "b2b", 1'b1, v[5].pt, 1'b1);
        // Abandon a block mid-flight with an asynchronous reset.
        @(negedge clk);
        start(v[0].ct, 1'b1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst out", out_a, 0);
        check("midrst busy", busy_a, 0);
        check("midrst key_ready", kr_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 15 && !kr_a; k++) begin
            @(negedge clk);
            if (ov_a) ov_seen++;
        end
        check("midrst key_ready again", kr_a, 1);
        check("midrst no pulse", ov_seen, 0);
        start(v[0].ct, 1'b1);
        finish_block(1'b0, v[0].pt, "after_rst", 1'b0, '0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
